// File: rtl/imm_gen_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | imm_gen_stage: registered RISC-V immediate generator, 2-entry skid buffer  |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module imm_gen_stage #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [2:0] SEL_I  = 3'b000;
  localparam logic [2:0] SEL_S  = 3'b001;
  localparam logic [2:0] SEL_B  = 3'b010;
  localparam logic [2:0] SEL_J  = 3'b011;
  localparam logic [2:0] SEL_U  = 3'b100;
  localparam logic [2:0] SEL_Z  = 3'b101;
  localparam logic [2:0] SEL_SH = 3'b110;

  logic             s;
  logic [63:0]      shamt;
  logic [63:0]      imm_wide;
  logic [XLEN-1:0]  imm_new;
  logic             err_new;
  logic             accept;
  logic             deliver;
  logic             unused_bits;

  logic             or_valid;
  logic [XLEN-1:0]  or_imm;
  logic [TAG_W-1:0] or_tag;
  logic             or_err;
  logic             sk_valid;
  logic [XLEN-1:0]  sk_imm;
  logic [TAG_W-1:0] sk_tag;
  logic             sk_err;

  assign s = in_instr[31];

  generate
    if (XLEN == 64) begin : g_sh64
      assign shamt = {58'b0, in_instr[25:20]};
    end else begin : g_sh32
      assign shamt = {59'b0, in_instr[24:20]};
    end
  endgenerate

  // Build at 64 bits and truncate so U needs no zero-width replication at XLEN=32.
  always_comb begin
    imm_wide = '0;
    err_new  = 1'b0;
    case (in_sel)
      SEL_I:   imm_wide = {{52{s}}, in_instr[31:20]};
      SEL_S:   imm_wide = {{52{s}}, in_instr[31:25], in_instr[11:7]};
      SEL_B:   imm_wide = {{52{s}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      SEL_J:   imm_wide = {{44{s}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      SEL_U:   imm_wide = {{32{s}}, in_instr[31:12], 12'b0};
      SEL_Z:   imm_wide = {59'b0, in_instr[19:15]};
      SEL_SH:  imm_wide = shamt;
      default: err_new  = 1'b1;
    endcase
  end

  assign imm_new     = imm_wide[XLEN-1:0];
  assign unused_bits = ^{in_instr[6:0], imm_wide};

  // in_ready depends only on skid occupancy, never on out_ready.
  assign in_ready  = ~sk_valid;
  assign accept    = in_valid & in_ready;
  assign deliver   = or_valid & out_ready;

  assign out_valid = or_valid;
  assign out_imm   = or_imm;
  assign out_tag   = or_tag;
  assign out_err   = or_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      or_valid <= 1'b0;
      or_imm   <= '0;
      or_tag   <= '0;
      or_err   <= 1'b0;
      sk_valid <= 1'b0;
      sk_imm   <= '0;
      sk_tag   <= '0;
      sk_err   <= 1'b0;
    end else if (sk_valid) begin
      if (deliver) begin
        or_imm   <= sk_imm;
        or_tag   <= sk_tag;
        or_err   <= sk_err;
        sk_valid <= 1'b0;
      end
    end else if (accept && (!or_valid || deliver)) begin
      or_valid <= 1'b1;
      or_imm   <= imm_new;
      or_tag   <= in_tag;
      or_err   <= err_new;
    end else if (accept) begin
      sk_valid <= 1'b1;
      sk_imm   <= imm_new;
      sk_tag   <= in_tag;
      sk_err   <= err_new;
    end else if (deliver) begin
      or_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (accept && err_new && (err_cnt != {CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_imm_gen_stage: directed vectors on a 32-bit and a 64-bit/CNT_W=2 copy   |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_imm_gen_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [2:0]  in_sel;
  logic [3:0]  in_tag;
  logic        out_ready;

  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_imm;
  logic [3:0]  out_tag;
  logic        out_err;
  logic [15:0] err_cnt;

  logic        in_ready64;
  logic        out_valid64;
  logic [63:0] out_imm64;
  logic [3:0]  out_tag64;
  logic        out_err64;
  logic [1:0]  err_cnt64;

  int total;
  int bad;

  imm_gen_stage #(.XLEN(32), .TAG_W(4), .CNT_W(16)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_sel(in_sel), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_tag(out_tag), .out_err(out_err), .err_cnt(err_cnt)
  );

  imm_gen_stage #(.XLEN(64), .TAG_W(4), .CNT_W(2)) u_dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_sel(in_sel), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
    .out_tag(out_tag64), .out_err(out_err64), .err_cnt(err_cnt64)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] sel, input logic [31:0] instr,
                       input logic [3:0] tag);
    in_valid = v;
    in_sel   = sel;
    in_instr = instr;
    in_tag   = tag;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Push one item with out_ready high and check it on the next cycle.
  task automatic push_chk(input string name, input logic [2:0] sel, input logic [31:0] instr,
                          input logic [3:0] tag, input logic [31:0] e32, input logic [63:0] e64,
                          input logic e_err);
    drive(1'b1, sel, instr, tag);
    step();
    check({name, "_valid"}, 64'(out_valid), 64'd1);
    check({name, "_imm"},   64'(out_imm),   64'(e32));
    check({name, "_tag"},   64'(out_tag),   64'(tag));
    check({name, "_err"},   64'(out_err),   64'(e_err));
    check({name, "_imm64"}, out_imm64,      e64);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 3'b000, 32'h0, 4'h0);
    step();
    step();
    rst = 1'b0;
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_imm",   64'(out_imm),   64'd0);
    check("rst_out_tag",   64'(out_tag),   64'd0);
    check("rst_out_err",   64'(out_err),   64'd0);
    check("rst_err_cnt",   64'(err_cnt),   64'd0);

    push_chk("i",  3'b000, 32'hFFF00093, 4'd3, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    push_chk("s",  3'b001, 32'hFE20AE23, 4'd1, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
    push_chk("b",  3'b010, 32'hFE000CE3, 4'd2, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 1'b0);
    push_chk("j",  3'b011, 32'h0010006F, 4'd4, 32'h00000800, 64'h0000000000000800, 1'b0);
    push_chk("u",  3'b100, 32'h12345037, 4'd8, 32'h12345000, 64'h0000000012345000, 1'b0);
    push_chk("z",  3'b101, 32'h000F8073, 4'd9, 32'h0000001F, 64'h000000000000001F, 1'b0);
    push_chk("sh", 3'b110, 32'h01F0D093, 4'hA, 32'h0000001F, 64'h000000000000001F, 1'b0);
    push_chk("un", 3'b100, 32'h80000037, 4'hB, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0);

    // Backpressure: drain, then fill both entries with out_ready low.
    drive(1'b0, 3'b000, 32'h0, 4'h0);
    step();
    check("drain_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
    drive(1'b1, 3'b000, 32'h00500093, 4'd5);
    step();
    check("bp1_in_ready", 64'(in_ready), 64'd1);
    check("bp1_tag",      64'(out_tag),  64'd5);
    drive(1'b1, 3'b000, 32'h00600093, 4'd6);
    step();
    check("bp2_in_ready", 64'(in_ready), 64'd0);
    check("bp2_imm_hold", 64'(out_imm),  64'd5);
    drive(1'b1, 3'b100, 32'h0ABCD037, 4'd7);
    step();
    check("bp3_in_ready", 64'(in_ready),  64'd0);
    check("bp3_valid",    64'(out_valid), 64'd1);
    check("bp3_tag_hold", 64'(out_tag),   64'd5);
    out_ready = 1'b1;
    step();
    check("bp4_imm",      64'(out_imm),  64'd6);
    check("bp4_tag",      64'(out_tag),  64'd6);
    check("bp4_in_ready", 64'(in_ready), 64'd1);
    step();
    check("bp5_imm", 64'(out_imm), 64'h0ABCD000);
    check("bp5_tag", 64'(out_tag), 64'd7);
    drive(1'b0, 3'b000, 32'h0, 4'h0);
    step();
    check("bp6_valid", 64'(out_valid), 64'd0);

    // Illegal selects: count on accept, narrow counter saturates.
    push_chk("il1", 3'b111, 32'hFFFFFFFF, 4'd1, 32'h0, 64'h0, 1'b1);
    push_chk("il2", 3'b111, 32'h12345678, 4'd2, 32'h0, 64'h0, 1'b1);
    push_chk("il3", 3'b111, 32'h80000000, 4'd3, 32'h0, 64'h0, 1'b1);
    check("il3_cnt",   64'(err_cnt),   64'd3);
    check("il3_cnt64", 64'(err_cnt64), 64'd3);
    push_chk("il4", 3'b111, 32'h0, 4'd4, 32'h0, 64'h0, 1'b1);
    push_chk("il5", 3'b111, 32'h0, 4'd5, 32'h0, 64'h0, 1'b1);
    check("il5_cnt",   64'(err_cnt),   64'd5);
    check("il5_cnt64", 64'(err_cnt64), 64'd3);
    drive(1'b0, 3'b111, 32'h0, 4'h0);
    step();
    check("idle_cnt", 64'(err_cnt), 64'd5);

    // Reset while full drops everything.
    out_ready = 1'b0;
    drive(1'b1, 3'b000, 32'h00100093, 4'hC);
    step();
    drive(1'b1, 3'b000, 32'h00200093, 4'hD);
    step();
    check("full_in_ready", 64'(in_ready), 64'd0);
    drive(1'b0, 3'b000, 32'h0, 4'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rf_valid",    64'(out_valid), 64'd0);
    check("rf_in_ready", 64'(in_ready),  64'd1);
    check("rf_cnt",      64'(err_cnt),   64'd0);
    check("rf_imm",      64'(out_imm),   64'd0);
    out_ready = 1'b1;
    step();
    check("rf_no_stale", 64'(out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
